test_pattern_gen: RTL and testbench

TEST_PATTERN_GEN -- requirements
Module: test_pattern_gen

---
 rtl/test_pattern_gen.sv | 179 +++++++++++++++++
 tb/tb_test_pattern_gen.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/test_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module      : test_pattern_gen
// Description : LED driver test-pattern generator. Waits CONF_DELAY cycles
//               after reset and requests driver configuration. It then
//               streams SINGLE / ALL / WALK / CHECKER patterns column by
//               column, rotating the row-select on each column_ready.
//               Column-start pulses come from a POS_PERIOD timer, or from a
//               synchronised hall sensor when HALL_SYNC_EN is defined.
// Options     : `define HALL_SYNC_EN -> hall-sensor position sync
// Revision    : 1.0 - initial release
// ============================================================================
module test_pattern_gen #(
  parameter int NB_DRIVERS = 30,
  parameter int NB_MUX     = 8,     // must be >= 2 for the row rotation
  parameter int CONF_DELAY = 50000,
  parameter int POS_PERIOD = 4096
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic [1:0]            mode,
  input  logic                  driver_ready,
  input  logic                  column_ready,
  input  logic                  hall_in,
  output logic [NB_DRIVERS-1:0] framebuffer_dat,
  output logic [NB_MUX-1:0]     fpga_mul,
  output logic                  position_sync,
  output logic                  new_configuration_ready
);

  localparam int CONF_W = $clog2(CONF_DELAY + 1);
  localparam int IDX_W  = $clog2(NB_DRIVERS + 1);

  localparam logic [1:0] ST_WAIT_CONF  = 2'd0;
  localparam logic [1:0] ST_WAIT_READY = 2'd1;
  localparam logic [1:0] ST_STREAM     = 2'd2;

  localparam logic [1:0] MODE_SINGLE  = 2'd0;
  localparam logic [1:0] MODE_WALK    = 2'd2;
  localparam logic [1:0] MODE_CHECKER = 2'd3;

  localparam logic [NB_MUX-1:0] MUL_MSB = {1'b1, {(NB_MUX-1){1'b0}}};

  logic [1:0]            r_state;
  logic [CONF_W-1:0]     r_conf_cnt;
  logic                  r_ncr;
  logic [1:0]            r_mode_q;
  logic [IDX_W-1:0]      r_walk;
  logic                  r_phase;
  logic [NB_DRIVERS-1:0] r_fb;
  logic [NB_MUX-1:0]     r_mul;
  logic                  r_pos_sync;
  logic [IDX_W-1:0]      w_walk_next;

  // Pixel pattern for a given mode, walk index and checker phase.
  function automatic logic [NB_DRIVERS-1:0] f_pattern(input logic [1:0] m,
                                                      input logic [IDX_W-1:0] idx,
                                                      input logic ph);
    logic [NB_DRIVERS-1:0] v;
    v = '1;
    case (m)
      MODE_WALK:    v = NB_DRIVERS'(1) << idx;
      MODE_CHECKER: for (int i = 0; i < NB_DRIVERS; i++) v[i] = i[0] ^ ph;
      default:      v = '1;
    endcase
    return v;
  endfunction

  // Walk index advances once per full row sweep and wraps after the last driver.
  assign w_walk_next = (r_walk == IDX_W'(NB_DRIVERS - 1)) ? '0 : r_walk + IDX_W'(1);

  // Control FSM plus registered pattern/row outputs (1-cycle latency from column_ready).
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state    <= ST_WAIT_CONF;
      r_conf_cnt <= '0;
      r_ncr      <= 1'b0;
      r_mode_q   <= MODE_SINGLE;
      r_walk     <= '0;
      r_phase    <= 1'b0;
      r_fb       <= '0;
      r_mul      <= '0;
    end else begin
      r_ncr <= 1'b0;
      case (r_state)
        ST_WAIT_CONF: begin
          if (r_conf_cnt == CONF_W'(CONF_DELAY - 1)) begin
            r_conf_cnt <= '0;
            r_ncr      <= 1'b1;
            r_state    <= ST_WAIT_READY;
          end else begin
            r_conf_cnt <= r_conf_cnt + CONF_W'(1);
          end
        end
        ST_WAIT_READY: begin
          // Outputs hold here; a fresh frame starts on entry to STREAM.
          if (driver_ready) begin
            r_state  <= ST_STREAM;
            r_mode_q <= mode;
            r_mul    <= MUL_MSB;
            r_walk   <= '0;
            r_phase  <= 1'b0;
            r_fb     <= f_pattern(mode, '0, 1'b0);
          end
        end
        ST_STREAM: begin
          if (!driver_ready) begin
            r_state <= ST_WAIT_READY;
          end else if (column_ready && (r_mode_q != MODE_SINGLE)) begin
            r_mul   <= {r_mul[0], r_mul[NB_MUX-1:1]};
            r_phase <= ~r_phase;
            if (r_mul[0]) begin
              // Frame boundary: the only point where a new mode is accepted.
              r_mode_q <= mode;
              r_walk   <= w_walk_next;
              r_fb     <= f_pattern(mode, w_walk_next, ~r_phase);
            end else begin
              r_fb <= f_pattern(r_mode_q, r_walk, ~r_phase);
            end
          end
        end
        default: r_state <= ST_WAIT_CONF;
      endcase
    end
  end

`ifdef HALL_SYNC_EN
  logic r_hall_s1;
  logic r_hall_s2;
  logic r_hall_d;

  // Two-flop synchroniser and rising-edge detector for the hall sensor.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_hall_s1  <= 1'b0;
      r_hall_s2  <= 1'b0;
      r_hall_d   <= 1'b0;
      r_pos_sync <= 1'b0;
    end else begin
      r_hall_s1  <= hall_in;
      r_hall_s2  <= r_hall_s1;
      r_hall_d   <= r_hall_s2;
      r_pos_sync <= (r_state == ST_STREAM) && r_hall_s2 && !r_hall_d;
    end
  end
`else
  localparam int POS_W = $clog2(POS_PERIOD + 1);

  logic [POS_W-1:0] r_pos_cnt;
  logic             w_unused_hall;

  // Sensor input has no function in the timer build.
  assign w_unused_hall = hall_in;

  // Free-running column timer, held cleared outside STREAM.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_pos_cnt  <= '0;
      r_pos_sync <= 1'b0;
    end else if (r_state != ST_STREAM) begin
      r_pos_cnt  <= '0;
      r_pos_sync <= 1'b0;
    end else if (r_pos_cnt == POS_W'(POS_PERIOD - 1)) begin
      r_pos_cnt  <= '0;
      r_pos_sync <= 1'b1;
    end else begin
      r_pos_cnt  <= r_pos_cnt + POS_W'(1);
      r_pos_sync <= 1'b0;
    end
  end
`endif

  assign framebuffer_dat         = r_fb;
  assign fpga_mul                = r_mul;
  assign position_sync           = r_pos_sync;
  assign new_configuration_ready = r_ncr;

endmodule
`default_nettype wire

// File: tb/tb_test_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_test_pattern_gen
// Description : Directed self-checking bench for test_pattern_gen
//               (NB_DRIVERS=30, NB_MUX=8, CONF_DELAY=10, POS_PERIOD=20).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_test_pattern_gen;

  localparam int NB_DRIVERS = 30;
  localparam int NB_MUX     = 8;
  localparam int CONF_DELAY = 10;
  localparam int POS_PERIOD = 20;

  localparam logic [29:0] FB_ONES = 30'h3FFFFFFF;
  localparam logic [29:0] FB_ODD  = 30'h2AAAAAAA;  // checker, phase 0
  localparam logic [29:0] FB_EVEN = 30'h15555555;  // checker, phase 1

  logic                  clk = 1'b0;
  logic                  nrst = 1'b0;
  logic [1:0]            mode = 2'd0;
  logic                  driver_ready = 1'b0;
  logic                  column_ready = 1'b0;
  logic                  hall_in = 1'b0;
  logic [NB_DRIVERS-1:0] framebuffer_dat;
  logic [NB_MUX-1:0]     fpga_mul;
  logic                  position_sync;
  logic                  new_configuration_ready;

  int assert_cnt = 0;
  int fail_cnt   = 0;

  test_pattern_gen #(
    .NB_DRIVERS(NB_DRIVERS),
    .NB_MUX    (NB_MUX),
    .CONF_DELAY(CONF_DELAY),
    .POS_PERIOD(POS_PERIOD)
  ) dut (
    .clk                    (clk),
    .nrst                   (nrst),
    .mode                   (mode),
    .driver_ready           (driver_ready),
    .column_ready           (column_ready),
    .hall_in                (hall_in),
    .framebuffer_dat        (framebuffer_dat),
    .fpga_mul               (fpga_mul),
    .position_sync          (position_sync),
    .new_configuration_ready(new_configuration_ready)
  );

  always #5 clk = ~clk;

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_column();
    column_ready = 1'b1;
    tick();
    column_ready = 1'b0;
  endtask

  task automatic leave_stream();
    driver_ready = 1'b0;
    column_ready = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    nrst = 1'b0;
    repeat (3) tick();
    assert_cnt++;
    if (framebuffer_dat !== '0 || fpga_mul !== '0 || position_sync !== 1'b0 ||
        new_configuration_ready !== 1'b0) begin
      fail_cnt++;
      $display("FAIL reset_state: fb=%h mul=%h ps=%b ncr=%b, required all zero",
               framebuffer_dat, fpga_mul, position_sync, new_configuration_ready);
    end
    nrst = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      assert_cnt++;
      if (new_configuration_ready !== (k == 10)) begin
        fail_cnt++;
        $display("FAIL conf_pulse cycle %0d: ncr=%b required %b", k,
                 new_configuration_ready, (k == 10));
      end
      if (k < 10) begin
        assert_cnt++;
        if (framebuffer_dat !== '0 || fpga_mul !== '0 || position_sync !== 1'b0) begin
          fail_cnt++;
          $display("FAIL conf_wait_outputs cycle %0d: fb=%h mul=%h ps=%b required zero",
                   k, framebuffer_dat, fpga_mul, position_sync);
        end
      end
    end
  endtask

  task automatic test_single();
    mode = 2'd0;
    driver_ready = 1'b1;
    tick();
    for (int p = 0; p <= 5; p++) begin
      if (p > 0) begin
        pulse_column();
        tick();
      end
      assert_cnt++;
      if (framebuffer_dat !== FB_ONES || fpga_mul !== 8'h80) begin
        fail_cnt++;
        $display("FAIL single pulse %0d: fb=%h mul=%h required fb=%h mul=80",
                 p, framebuffer_dat, fpga_mul, FB_ONES);
      end
    end
    leave_stream();
  endtask

  task automatic test_walk();
    logic [29:0] exp_fb;
    logic [7:0]  exp_mul;
    mode = 2'd2;
    driver_ready = 1'b1;
    tick();
    for (int p = 0; p <= 16; p++) begin
      if (p > 0) pulse_column();
      exp_fb  = 30'd1 << (p / 8);
      exp_mul = 8'h80 >> (p % 8);
      assert_cnt++;
      if (framebuffer_dat !== exp_fb || fpga_mul !== exp_mul) begin
        fail_cnt++;
        $display("FAIL walk pulse %0d: fb=%h mul=%h required fb=%h mul=%h",
                 p, framebuffer_dat, fpga_mul, exp_fb, exp_mul);
      end
    end
    leave_stream();
  endtask

  task automatic test_mode_change();
    logic [29:0] exp_fb;
    logic [7:0]  exp_mul;
    mode = 2'd3;
    driver_ready = 1'b1;
    tick();
    for (int p = 0; p <= 8; p++) begin
      if (p > 0) pulse_column();
      if (p == 3) mode = 2'd1;
      if (p == 8)          exp_fb = FB_ONES;
      else if (p % 2 == 1) exp_fb = FB_EVEN;
      else                 exp_fb = FB_ODD;
      exp_mul = 8'h80 >> (p % 8);
      assert_cnt++;
      if (framebuffer_dat !== exp_fb || fpga_mul !== exp_mul) begin
        fail_cnt++;
        $display("FAIL mode_change pulse %0d: fb=%h mul=%h required fb=%h mul=%h",
                 p, framebuffer_dat, fpga_mul, exp_fb, exp_mul);
      end
    end
    leave_stream();
  endtask

`ifdef HALL_SYNC_EN
  task automatic test_hall_sync();
    mode = 2'd1;
    hall_in = 1'b0;
    driver_ready = 1'b1;
    tick();
    for (int k = 1; k <= 2 * POS_PERIOD + 5; k++) begin
      tick();
      assert_cnt++;
      if (position_sync !== 1'b0) begin
        fail_cnt++;
        $display("FAIL hall_no_timer cycle %0d: ps=%b required 0", k, position_sync);
      end
    end
    hall_in = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      assert_cnt++;
      if (position_sync !== (k == 3)) begin
        fail_cnt++;
        $display("FAIL hall_edge cycle %0d: ps=%b required %b", k, position_sync, (k == 3));
      end
    end
    hall_in = 1'b0;
    leave_stream();
  endtask
`else
  task automatic test_timer();
    logic exp_ps;
    mode = 2'd1;
    hall_in = 1'b0;
    driver_ready = 1'b1;
    tick();
    for (int k = 1; k <= 2 * POS_PERIOD + 1; k++) begin
      // Toggle the sensor to show it has no influence in this build.
      hall_in = k[1];
      if (k == 2 * POS_PERIOD) column_ready = 1'b1;
      tick();
      column_ready = 1'b0;
      exp_ps = (k == POS_PERIOD) || (k == 2 * POS_PERIOD);
      assert_cnt++;
      if (position_sync !== exp_ps) begin
        fail_cnt++;
        $display("FAIL timer cycle %0d: ps=%b required %b", k, position_sync, exp_ps);
      end
      if (k == 2 * POS_PERIOD) begin
        assert_cnt++;
        if (fpga_mul !== 8'h40) begin
          fail_cnt++;
          $display("FAIL sync_with_column: mul=%h required 40", fpga_mul);
        end
      end
    end
    hall_in = 1'b0;
    leave_stream();
  endtask
`endif

  task automatic test_reset_midstream();
    mode = 2'd2;
    driver_ready = 1'b1;
    tick();
    repeat (3) pulse_column();
    leave_stream();
    mode = 2'd1;
    pulse_column();
    repeat (3) tick();
    assert_cnt++;
    if (framebuffer_dat !== 30'd1 || fpga_mul !== 8'h10) begin
      fail_cnt++;
      $display("FAIL hold_wait_ready: fb=%h mul=%h required fb=00000001 mul=10",
               framebuffer_dat, fpga_mul);
    end
    // Assert reset mid-cycle and check before the next rising edge.
    #2;
    nrst = 1'b0;
    #1;
    assert_cnt++;
    if (framebuffer_dat !== '0 || fpga_mul !== '0 || position_sync !== 1'b0 ||
        new_configuration_ready !== 1'b0) begin
      fail_cnt++;
      $display("FAIL async_reset: fb=%h mul=%h ps=%b ncr=%b required all zero",
               framebuffer_dat, fpga_mul, position_sync, new_configuration_ready);
    end
    tick();
    nrst = 1'b1;
    for (int k = 1; k <= 11; k++) begin
      tick();
      assert_cnt++;
      if (new_configuration_ready !== (k == 10)) begin
        fail_cnt++;
        $display("FAIL reconf_pulse cycle %0d: ncr=%b required %b", k,
                 new_configuration_ready, (k == 10));
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_walk();
    test_mode_change();
`ifdef HALL_SYNC_EN
    test_hall_sync();
`else
    test_timer();
`endif
    test_reset_midstream();
    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule
`default_nettype wire
